// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the single-ported-memory datapath.
// Adds LW/SW wait states, BNE, TRAP on illegal opcodes and a saturating retired-instruction counter.
module mc_control_unit #(
  parameter int COUNT_W = 16,
  parameter int MEM_EN  = 1,
  parameter int TRAP_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               halted,
  output logic               illegal_op,
  output logic [3:0]         state_o,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_WB_I      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_END    = 6'b111111;

  localparam state_t             ILLEGAL_DEST = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
  localparam logic [COUNT_W-1:0] COUNT_MAX    = {COUNT_W{1'b1}};

  state_t             state_r;
  state_t             next_state_s;
  logic [5:0]         op_r;
  logic [5:0]         next_op_s;
  logic               retire_s;
  logic               fetch_s;
  logic [COUNT_W-1:0] count_r;
  ctrl_t              ctrl_r;

  // Moore control decode for a state; FETCH's IRWrite/PCWrite gating by mem_ready is applied outside.
  function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '{default: 1'b0};
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_WB_I:     c.reg_write = 1'b1;
      S_MEM_READ: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_source     = 2'b01;
        c.pc_write_cond = 1'b1;
        c.branch_ne     = (op == OP_BNE);
      end
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_HALT:  c.halted  = 1'b1;
      S_TRAP:  c.illegal = 1'b1;
      default: c = '{default: 1'b0};
    endcase
    return c;
  endfunction

  // Next-state, opcode latch and retirement decode.
  always_comb begin
    next_state_s = S_FETCH;
    next_op_s    = op_r;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        next_op_s = opCode;
        case (opCode)
          OP_R_TYPE:     next_state_s = S_EXEC_R;
          OP_ADDI:       next_state_s = S_EXEC_I;
          OP_LW, OP_SW:  next_state_s = (MEM_EN != 0) ? S_MEM_ADDR : ILLEGAL_DEST;
          OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
          OP_J:          next_state_s = S_JUMP;
          OP_END:        next_state_s = S_HALT;
          default:       next_state_s = ILLEGAL_DEST;
        endcase
      end
      S_EXEC_R:   next_state_s = S_WB_R;
      S_EXEC_I:   next_state_s = S_WB_I;
      S_MEM_ADDR: begin
        if (op_r == OP_LW) next_state_s = S_MEM_READ;
        else               next_state_s = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        if (mem_ready) next_state_s = S_MEM_WB;
        else           next_state_s = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          next_state_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          next_state_s = S_MEM_WRITE;
        end
      end
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: begin
        next_state_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_HALT:  next_state_s = S_HALT;
      S_TRAP:  next_state_s = S_TRAP;
      default: next_state_s = S_FETCH;
    endcase
  end

  // State, latched opcode, retire counter and registered controls for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
      op_r    <= 6'd0;
      count_r <= {COUNT_W{1'b0}};
      ctrl_r  <= ctrl_decode(S_FETCH, 6'd0);
    end else begin
      state_r <= next_state_s;
      op_r    <= next_op_s;
      ctrl_r  <= ctrl_decode(next_state_s, next_op_s);
      if (retire_s && (count_r != COUNT_MAX)) begin
        count_r <= count_r + COUNT_W'(1'b1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign fetch_s     = (state_r == S_FETCH);
  assign ALUOp       = ctrl_r.alu_op;
  assign ALUSrcA     = ctrl_r.alu_src_a;
  assign ALUSrcB     = ctrl_r.alu_src_b;
  assign PCSource    = ctrl_r.pc_source;
  assign PCWrite     = ctrl_r.pc_write | (fetch_s & mem_ready);
  assign PCWriteCond = ctrl_r.pc_write_cond;
  assign BranchNe    = ctrl_r.branch_ne;
  assign IorD        = ctrl_r.i_or_d;
  assign MemRead     = ctrl_r.mem_read;
  assign MemWrite    = ctrl_r.mem_write;
  assign MemtoReg    = ctrl_r.mem_to_reg;
  assign IRWrite     = fetch_s & mem_ready;
  assign RegWrite    = ctrl_r.reg_write;
  assign RegDst      = ctrl_r.reg_dst;
  assign halted      = ctrl_r.halted;
  assign illegal_op  = ctrl_r.illegal;
  assign state_o     = state_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: instance 0 uses defaults, instance 1 has COUNT_W=2 and TRAP_EN=0.
module tb_mc_control_unit;

  typedef struct {
    int          inst;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_v;
  logic [1:0]  mr_v;
  logic [5:0]  op_v  [2];
  logic [3:0]  st_v  [2];
  logic [18:0] ctl_v [2];
  logic [15:0] cnt_v [2];

  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [5:0]  opq_m [2];
  logic [15:0] cnt_m [2];
  logic [15:0] cmax_m [2];
  int          n_cmp;
  int          n_bad;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int CW = (g == 0) ? 16 : 2;
      logic [1:0]    alu_op, alu_src_b, pc_source;
      logic          alu_src_a, pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
      logic          mem_to_reg, ir_write, reg_write, reg_dst, halted, illegal_op;
      logic [3:0]    state;
      logic [CW-1:0] cnt;

      mc_control_unit #(.COUNT_W(CW), .MEM_EN(1), .TRAP_EN((g == 0) ? 1 : 0)) dut (
        .clk(clk), .reset(rst_v[g]), .opCode(op_v[g]), .mem_ready(mr_v[g]),
        .ALUOp(alu_op), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .PCSource(pc_source),
        .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .BranchNe(branch_ne), .IorD(i_or_d),
        .MemRead(mem_read), .MemWrite(mem_write), .MemtoReg(mem_to_reg), .IRWrite(ir_write),
        .RegWrite(reg_write), .RegDst(reg_dst), .halted(halted), .illegal_op(illegal_op),
        .state_o(state), .instr_count(cnt)
      );

      assign ctl_v[g] = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
                         branch_ne, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
                         reg_write, reg_dst, halted, illegal_op};
      assign st_v[g]  = state;
      assign cnt_v[g] = 16'(cnt);
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected controls per state, written from the state table.
  function automatic logic [18:0] exp_ctrl(input int s, input logic [5:0] opq, input logic mr);
    logic [1:0] aop, sb, pcs;
    logic sa, pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rd, hlt, ill;
    {aop, sb, pcs} = 6'd0;
    {sa, pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rd, hlt, ill} = 13'd0;
    case (s)
      0:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1'b1; aop = 2'b10; end
      3:  begin rd = 1'b1; rw = 1'b1; end
      4:  begin sa = 1'b1; sb = 2'b10; end
      5:  rw = 1'b1;
      6:  begin sa = 1'b1; sb = 2'b10; end
      7:  begin iord = 1'b1; mrd = 1'b1; end
      8:  begin m2r = 1'b1; rw = 1'b1; end
      9:  begin iord = 1'b1; mwr = 1'b1; end
      10: begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; pcwc = 1'b1; bne = (opq == 6'b000101); end
      11: begin pcs = 2'b10; pcw = 1'b1; end
      12: hlt = 1'b1;
      13: ill = 1'b1;
      default: hlt = 1'b0;
    endcase
    return {aop, sa, sb, pcs, pcw, pcwc, bne, iord, mrd, mwr, m2r, irw, rw, rd, hlt, ill};
  endfunction

  // One cycle of stimulus on instance i, with the state expected during that cycle.
  task automatic cyc(input int i, input logic [5:0] op, input logic mr, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    op_v[i] = op;
    mr_v[i] = mr;
    e.inst = i;
    e.st   = 4'(st);
    e.ctl  = exp_ctrl(st, opq_m[i], mr);
    e.cnt  = cnt_m[i];
    sb_q.push_back(e);
  endtask

  task automatic hold(input int i, input int st, input int n);
    for (int k = 0; k < n; k++) cyc(i, 6'($urandom), 1'($urandom), st);
  endtask

  task automatic do_reset(input int i);
    exp_t e;
    @(posedge clk);
    #1;
    rst_v[i] = 1'b0;
    mr_v[i]  = 1'b0;
    cnt_m[i] = 16'd0;
    opq_m[i] = 6'd0;
    e.inst = i;
    e.st   = 4'd0;
    e.ctl  = exp_ctrl(0, 6'd0, 1'b0);
    e.cnt  = 16'd0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    rst_v[i] = 1'b1;
  endtask

  // Full instruction: fw FETCH wait cycles, mw memory wait cycles.
  task automatic instr(input int i, input logic [5:0] op, input int fw, input int mw);
    logic ret;
    ret = 1'b1;
    for (int k = 0; k < fw; k++) cyc(i, 6'($urandom), 1'b0, 0);
    cyc(i, 6'($urandom), 1'b1, 0);
    cyc(i, op, 1'($urandom), 1);
    opq_m[i] = op;
    case (op)
      6'b000000: begin cyc(i, 6'($urandom), 1'($urandom), 2); cyc(i, 6'($urandom), 1'($urandom), 3); end
      6'b001000: begin cyc(i, 6'($urandom), 1'($urandom), 4); cyc(i, 6'($urandom), 1'($urandom), 5); end
      6'b100011: begin
        cyc(i, 6'($urandom), 1'($urandom), 6);
        for (int k = 0; k < mw; k++) cyc(i, 6'($urandom), 1'b0, 7);
        cyc(i, 6'($urandom), 1'b1, 7);
        cyc(i, 6'($urandom), 1'($urandom), 8);
      end
      6'b101011: begin
        cyc(i, 6'($urandom), 1'($urandom), 6);
        for (int k = 0; k < mw; k++) cyc(i, 6'($urandom), 1'b0, 9);
        cyc(i, 6'($urandom), 1'b1, 9);
      end
      6'b000100, 6'b000101: cyc(i, 6'($urandom), 1'($urandom), 10);
      6'b000010: cyc(i, 6'($urandom), 1'($urandom), 11);
      6'b111111: begin cyc(i, 6'($urandom), 1'($urandom), 12); ret = 1'b0; end
      default: begin
        if (i == 0) cyc(i, 6'($urandom), 1'($urandom), 13);
        ret = 1'b0;
      end
    endcase
    if (ret) cnt_m[i] = (cnt_m[i] == cmax_m[i]) ? cnt_m[i] : cnt_m[i] + 16'd1;
  endtask

  // Reset dropped in the middle of a MEM_WRITE wait, between clock edges.
  task automatic sw_reset(input int i);
    cyc(i, 6'($urandom), 1'b1, 0);
    cyc(i, 6'b101011, 1'($urandom), 1);
    opq_m[i] = 6'b101011;
    cyc(i, 6'($urandom), 1'($urandom), 6);
    @(posedge clk);
    #1;
    mr_v[i] = 1'b0;
    #1;
    check_eq("memwrite_before_reset", 32'(ctl_v[i][6]), 32'd1);
    check_eq("state_before_reset", 32'(st_v[i]), 32'd9);
    rst_v[i] = 1'b0;
    #1;
    check_eq("memwrite_async_reset", 32'(ctl_v[i][6]), 32'd0);
    check_eq("state_async_reset", 32'(st_v[i]), 32'd0);
    check_eq("count_async_reset", 32'(cnt_v[i]), 32'd0);
    cnt_m[i] = 16'd0;
  endtask

  // Scoreboard pop and compare, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_eq($sformatf("u%0d_state", mon_e.inst), 32'(st_v[mon_e.inst]), 32'(mon_e.st));
      check_eq($sformatf("u%0d_ctrl_s%0d", mon_e.inst, mon_e.st), 32'(ctl_v[mon_e.inst]), 32'(mon_e.ctl));
      check_eq($sformatf("u%0d_count", mon_e.inst), 32'(cnt_v[mon_e.inst]), 32'(mon_e.cnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_v     = 2'b00;
    mr_v      = 2'b00;
    op_v[0]   = 6'd0;
    op_v[1]   = 6'd0;
    opq_m[0]  = 6'd0;
    opq_m[1]  = 6'd0;
    cnt_m[0]  = 16'd0;
    cnt_m[1]  = 16'd0;
    cmax_m[0] = 16'hFFFF;
    cmax_m[1] = 16'd3;

    do_reset(0);
    instr(0, 6'b000000, 0, 0);
    instr(0, 6'b001000, 1, 0);
    instr(0, 6'b100011, 0, 2);
    instr(0, 6'b101011, 2, 1);
    instr(0, 6'b000100, 0, 0);
    instr(0, 6'b000101, 0, 0);
    instr(0, 6'b000010, 0, 0);
    instr(0, 6'b101010, 0, 0);
    hold(0, 13, 9);
    do_reset(0);
    instr(0, 6'b000000, 0, 0);
    instr(0, 6'b111111, 0, 0);
    hold(0, 12, 5);
    do_reset(0);
    instr(0, 6'b000010, 0, 0);
    cyc(0, 6'($urandom), 1'b0, 0);
    sw_reset(0);

    do_reset(1);
    instr(1, 6'b101010, 0, 0);
    for (int k = 0; k < 5; k++) instr(1, 6'b000010, 0, 0);
    cyc(1, 6'($urandom), 1'b0, 0);
    cyc(1, 6'($urandom), 1'b0, 0);

    @(posedge clk);
    @(posedge clk);
    check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multi-cycle control FSM for the single-ported-memory datapath, the successor to the basic fetch/decode/execute controller. Adds load/store with memory wait states, BNE, PC increment folded into FETCH, a branch-target precompute in DECODE, a trap state for illegal opcodes, and a saturating retired-instruction counter. It sits between the instruction register opcode field and the datapath mux/enable controls.

## Interface
- COUNT_W, 16: width of `instr_count`.
- MEM_EN, 1: 1 enables LW/SW. 0 treats them as illegal opcodes.
- TRAP_EN, 1: 1 sends illegal opcodes to TRAP. 0 sends them back to FETCH with no side effects.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- opCode  in  6  IR[31:26]. Valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- ALUOp  out  2  00 ADD, 01 SUB, 10 FUNCT.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst  out  1 each  datapath controls.
- halted  out  1  in HALT.
- illegal_op  out  1  in TRAP.
- state_o  out  4  current state code.
- instr_count  out  COUNT_W  retired instructions, saturating.

## Operation
- Opcodes: R_TYPE 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, END 111111.
- `op_q` is latched from `opCode` on the DECODE edge. All states after DECODE decode `op_q`.
- All outputs are Moore (function of state, plus `op_q` and `mem_ready` where noted). Any output not listed for a state is 0.
- States, codes, outputs, and next state:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, IRWrite=PCWrite=mem_ready. Moves to DECODE when mem_ready, otherwise stays.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD. Next state by opCode: R→EXEC_R, ADDI→EXEC_I, LW/SW→MEM_ADDR, BEQ/BNE→BRANCH, J→JUMP, END→HALT, else TRAP (or FETCH if TRAP_EN=0).
  - EXEC_R(2): ALUSrcA=1, ALUSrcB=00, ALUOp=FUNCT. → WB_R.
  - WB_R(3): RegDst=1, RegWrite=1. → FETCH.
  - EXEC_I(4): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. → WB_I.
  - WB_I(5): RegDst=0, RegWrite=1. → FETCH.
  - MEM_ADDR(6): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. LW → MEM_READ, SW → MEM_WRITE.
  - MEM_READ(7): IorD=1, MemRead=1. Waits for mem_ready, then → MEM_WB.
  - MEM_WB(8): MemtoReg=1, RegDst=0, RegWrite=1. → FETCH.
  - MEM_WRITE(9): IorD=1, MemWrite=1, held until mem_ready. Then → FETCH.
  - BRANCH(10): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWriteCond=1, BranchNe=(op_q==BNE). → FETCH.
  - JUMP(11): PCSource=10, PCWrite=1. → FETCH.
  - HALT(12): halted=1. Terminal; exits only on reset.
  - TRAP(13): illegal_op=1. Terminal; exits only on reset.
  - Codes 14–15 → FETCH, all outputs 0.
- Retirement: `instr_count` increments by 1 on the edge leaving WB_R, WB_I, MEM_WB, BRANCH, JUMP, or MEM_WRITE (with mem_ready).
  - Saturates at 2^COUNT_W−1.
  - HALT, TRAP and the TRAP_EN=0 illegal path do not count.

## Timing
- Reset (reset=0), asynchronous: state=FETCH, op_q=0, instr_count=0.
  - Every output is driven 0 except the FETCH decode: MemRead=1, ALUSrcB=01, and IRWrite/PCWrite following mem_ready.
  - Reset mid-MEM_WRITE drops MemWrite in the same cycle, with no clock needed.
- Zero-wait cycle counts, including FETCH: R 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- In FETCH with mem_ready=0: PCWrite=IRWrite=0, so the PC does not advance.
- mem_ready is ignored in all other states.
- A change in opCode after DECODE has no effect.

## Test plan
- Reset, then mem_ready=1 with R_TYPE → states 0,1,2,3,0. RegWrite=RegDst=1 only in state 3. instr_count=1.
- LW with mem_ready low for 2 cycles in MEM_READ → 7 cycles total. MemtoReg=1 only in MEM_WB. Count +1.
- BNE → BRANCH with BranchNe=1, PCWriteCond=1, ALUOp=01. BEQ gives BranchNe=0.
- Opcode 101010 with TRAP_EN=1 → TRAP, illegal_op=1 held for 10 cycles, count unchanged. With TRAP_EN=0 → FETCH after DECODE.
- END → halted=1, held. Assert reset → state_o=0, halted=0, count=0.
- COUNT_W=2: run 5 J instructions → instr_count saturates at 3. reset=0 mid-MEM_WRITE → MemWrite falls in the same cycle.
